// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: general-purpose register file for the single-clock MIPS datapath.
// 2**AW registers of DW bits. There are two combinational read ports (rs/rt),
// one combinational debug read port and one clocked write port. Register 0 has
// no storage and always reads as zero. wr_cnt counts committed writes to nonzero
// registers and saturates at all-ones.
module reg_file_2r1w #(
    parameter int unsigned DW     = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned BYPASS = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic [AW-1:0] dbg_a,
    output logic [DW-1:0] dbg_d,
    output logic [15:0]   wr_cnt
);

    localparam int unsigned DEPTH = 2**AW;

    // Entry 0 is intentionally absent; the read logic supplies its zero.
    logic [DW-1:0] mem [1:DEPTH-1];

    logic wr_commit;
    logic byp_live;

    // A write commits only for a nonzero destination. Reset priority is applied
    // inside the sequential blocks.
    always_comb begin
        wr_commit = we && (wa != '0);
        byp_live  = (BYPASS != 0) && we && rst_n && (wa != '0);
    end

    // Storage update: reset clears every entry and discards a concurrent write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
        end else if (wr_commit) begin
            mem[wa] <= wd;
        end
    end

    // Count committed writes. The counter stops at 16'hFFFF.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt <= '0;
        end else if (wr_commit && (wr_cnt != 16'hFFFF)) begin
            wr_cnt <= wr_cnt + 16'd1;
        end
    end

    // Read port 1: zero for r0, write-through when bypass is live, else stored.
    always_comb begin
        rd1 = '0;
        if (ra1 != '0) begin
            if (byp_live && (ra1 == wa)) begin
                rd1 = wd;
            end else begin
                rd1 = mem[ra1];
            end
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        rd2 = '0;
        if (ra2 != '0) begin
            if (byp_live && (ra2 == wa)) begin
                rd2 = wd;
            end else begin
                rd2 = mem[ra2];
            end
        end
    end

    // Debug read port: same rules as the operand ports.
    always_comb begin
        dbg_d = '0;
        if (dbg_a != '0) begin
            if (byp_live && (dbg_a == wa)) begin
                dbg_d = wd;
            end else begin
                dbg_d = mem[dbg_a];
            end
        end
    end

endmodule
